// File: rtl/ecpeta_error_monitor_if.sv
// rtl/ecpeta_error_monitor_if.sv - sample/result handshake bundle for the ECPETA error monitor
interface ecpeta_error_monitor_if #(
    parameter int N       = 16,
    parameter int LOG_WIN = 10
);
    logic                 start;
    logic                 in_valid;
    logic                 in_ready;
    logic [N-1:0]         a;
    logic [N-1:0]         b;
    logic [N-1:0]         approx_sum;
    logic                 res_valid;
    logic                 res_ready;
    logic [LOG_WIN:0]     err_count;
    logic [N+LOG_WIN:0]   ed_sum;
    logic [N:0]           max_ed;
    logic                 busy;

    // Producer of samples and consumer of results
    modport master (
        output start, in_valid, a, b, approx_sum, res_ready,
        input  in_ready, res_valid, err_count, ed_sum, max_ed, busy
    );

    // The monitor itself
    modport slave (
        input  start, in_valid, a, b, approx_sum, res_ready,
        output in_ready, res_valid, err_count, ed_sum, max_ed, busy
    );
endinterface

// File: rtl/ecpeta_error_monitor.sv
// rtl/ecpeta_error_monitor.sv - windowed error-distance statistics for the ECPETA approximate adder
module ecpeta_error_monitor #(
    parameter int N       = 16,
    parameter int LOG_WIN = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    ecpeta_error_monitor_if.slave bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCUM  = 2'd1;
    localparam logic [1:0] S_FLUSH  = 2'd2;
    localparam logic [1:0] S_REPORT = 2'd3;

    // Counter value reached by the final accept of a window
    localparam logic [LOG_WIN:0] C_WIN = {1'b1, {LOG_WIN{1'b0}}};

    logic [1:0]         r_state;
    logic [LOG_WIN:0]   r_cnt;
    logic               r_s1_valid;
    logic [N:0]         r_s1_ed;
    logic [LOG_WIN:0]   r_err_count;
    logic [N+LOG_WIN:0] r_ed_sum;
    logic [N:0]         r_max_ed;

    logic               w_accept;
    logic [N:0]         w_exact;
    logic [N:0]         w_approx;
    logic [N:0]         w_ed;
    logic [LOG_WIN:0]   w_cnt_next;

    assign w_accept   = bus.in_valid && (r_state == S_ACCUM);
    assign w_exact    = {1'b0, bus.a} + {1'b0, bus.b};
    assign w_approx   = {1'b0, bus.approx_sum};
    // The approximate sum may land on either side of the exact one
    assign w_ed       = (w_exact >= w_approx) ? (w_exact - w_approx) : (w_approx - w_exact);
    assign w_cnt_next = r_cnt + 1'b1;

    // Control FSM and sample counter; start only matters in IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state <= S_ACCUM;
                        r_cnt   <= '0;
                    end
                end
                S_ACCUM: begin
                    if (w_accept) begin
                        r_cnt <= w_cnt_next;
                        if (w_cnt_next == C_WIN) r_state <= S_FLUSH;
                    end
                end
                S_FLUSH:  r_state <= S_REPORT;
                default: begin
                    if (bus.res_ready) r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Stage 1: register the error distance of each accepted sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_ed    <= '0;
        end else if (r_state == S_IDLE && bus.start) begin
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) r_s1_ed <= w_ed;
        end
    end

    // Stage 2: accumulate window statistics; results hold through REPORT and IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_count <= '0;
            r_ed_sum    <= '0;
            r_max_ed    <= '0;
        end else if (r_state == S_IDLE && bus.start) begin
            r_err_count <= '0;
            r_ed_sum    <= '0;
            r_max_ed    <= '0;
        end else if (r_s1_valid) begin
            r_ed_sum    <= r_ed_sum + {{LOG_WIN{1'b0}}, r_s1_ed};
            r_err_count <= r_err_count + {{LOG_WIN{1'b0}}, (r_s1_ed != '0)};
            if (r_s1_ed > r_max_ed) r_max_ed <= r_s1_ed;
        end
    end

    assign bus.in_ready  = (r_state == S_ACCUM);
    assign bus.res_valid = (r_state == S_REPORT);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.err_count = r_err_count;
    assign bus.ed_sum    = r_ed_sum;
    assign bus.max_ed    = r_max_ed;
endmodule

// File: tb/tb_ecpeta_error_monitor.sv
// tb/tb_ecpeta_error_monitor.sv - scoreboard bench for ecpeta_error_monitor with a 4-sample window
module tb_ecpeta_error_monitor;
    localparam int N       = 16;
    localparam int LOG_WIN = 2;

    typedef struct {
        logic [LOG_WIN:0]   err;
        logic [N+LOG_WIN:0] sum;
        logic [N:0]         mx;
    } res_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    res_t exp_q[$];

    ecpeta_error_monitor_if #(.N(N), .LOG_WIN(LOG_WIN)) bus ();

    ecpeta_error_monitor #(.N(N), .LOG_WIN(LOG_WIN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Result monitor: pops the scoreboard on every result handshake
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.res_valid && bus.res_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("err_count", 64'(bus.err_count), 64'(e.err));
                    chk("ed_sum",    64'(bus.ed_sum),    64'(e.sum));
                    chk("max_ed",    64'(bus.max_ed),    64'(e.mx));
                end
            end
        end
    end

    task automatic do_start();
        @(posedge clk); #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("in_ready_after_start", 64'(bus.in_ready), 64'd1);
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [15:0] s);
        bus.in_valid   = 1'b1;
        bus.a          = a;
        bus.b          = b;
        bus.approx_sum = s;
        @(posedge clk); #1;
        bus.in_valid   = 1'b0;
    endtask

    task automatic run_window(
        input logic [15:0] va[4], input logic [15:0] vb[4], input logic [15:0] vs[4],
        input bit bubbles, input int hold, input bit start_on_hs,
        input logic [LOG_WIN:0] e_err, input logic [N+LOG_WIN:0] e_sum, input logic [N:0] e_max);
        res_t e;
        logic [N+LOG_WIN:0] held_sum;
        e.err = e_err; e.sum = e_sum; e.mx = e_max;
        exp_q.push_back(e);
        do_start();
        for (int i = 0; i < 4; i++) begin
            send(va[i], vb[i], vs[i]);
            if (bubbles && i < 3) begin
                // bubble cycle with a stray start that must be ignored
                bus.start = (i == 1);
                @(posedge clk); #1;
                bus.start = 1'b0;
            end
        end
        chk("flush_res_valid", 64'(bus.res_valid), 64'd0);
        chk("flush_in_ready",  64'(bus.in_ready),  64'd0);
        @(posedge clk); #1;
        chk("report_res_valid", 64'(bus.res_valid), 64'd1);
        held_sum = bus.ed_sum;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_res_valid", 64'(bus.res_valid), 64'd1);
            chk("hold_in_ready",  64'(bus.in_ready),  64'd0);
            chk("hold_ed_sum",    64'(bus.ed_sum),    64'(e_sum));
        end
        chk("report_sum_stable", 64'(held_sum), 64'(e_sum));
        bus.res_ready = 1'b1;
        bus.start     = start_on_hs;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        bus.start     = 1'b0;
        chk("post_hs_res_valid", 64'(bus.res_valid), 64'd0);
        chk("post_hs_busy",      64'(bus.busy),      64'd0);
        chk("post_hs_in_ready",  64'(bus.in_ready),  64'd0);
        @(posedge clk); #1;
        chk("idle_err_kept",     64'(bus.err_count), 64'(e_err));
        chk("idle_busy",         64'(bus.busy),      64'd0);
    endtask

    logic [15:0] a1[4] = '{16'h1234, 16'hAAAA, 16'h0F0F, 16'h0000};
    logic [15:0] b1[4] = '{16'h5678, 16'h5555, 16'hF0F0, 16'h0000};
    logic [15:0] s1[4] = '{16'h68AC, 16'hFFFF, 16'hFFFF, 16'h0000};
    logic [15:0] a2[4] = '{16'h1234, 16'hFFFF, 16'hAAAA, 16'h0F0F};
    logic [15:0] b2[4] = '{16'h5678, 16'h0001, 16'h5555, 16'hF0F0};
    logic [15:0] s2[4] = '{16'h68A0, 16'h0000, 16'hFFFF, 16'hFFF0};
    logic [15:0] a3[4] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001};
    logic [15:0] s3[4] = '{16'h0003, 16'h0003, 16'h0003, 16'h0003};

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1;
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.res_ready = 1'b0;
        bus.a = '0; bus.b = '0; bus.approx_sum = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  64'(bus.in_ready),  64'd0);
        chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
        chk("rst_busy",      64'(bus.busy),      64'd0);
        chk("rst_err_count", 64'(bus.err_count), 64'd0);
        chk("rst_ed_sum",    64'(bus.ed_sum),    64'd0);
        chk("rst_max_ed",    64'(bus.max_ed),    64'd0);
        rst = 1'b0;

        run_window(a1, b1, s1, 1'b0, 0, 1'b0, 3'd0, 19'h0, 17'h0);
        run_window(a2, b2, s2, 1'b0, 0, 1'b0, 3'd3, 19'h1001B, 17'h10000);
        run_window(a3, a3, s3, 1'b0, 0, 1'b0, 3'd4, 19'h4, 17'h1);
        run_window(a2, b2, s2, 1'b1, 5, 1'b1, 3'd3, 19'h1001B, 17'h10000);

        // Abort a window part way through with reset
        do_start();
        send(a3[0], a3[0], s3[0]);
        send(a2[1], b2[1], s2[1]);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy",      64'(bus.busy),      64'd0);
        chk("midrst_in_ready",  64'(bus.in_ready),  64'd0);
        chk("midrst_err_count", 64'(bus.err_count), 64'd0);
        chk("midrst_ed_sum",    64'(bus.ed_sum),    64'd0);
        chk("midrst_max_ed",    64'(bus.max_ed),    64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_window(a2, b2, s2, 1'b0, 0, 1'b0, 3'd3, 19'h1001B, 17'h10000);

        repeat (2) @(posedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
